// File: rtl/drp_adc_responder.sv
// DRP register responder in front of a four-channel auxiliary ADC sequencer.
// Register access and conversions run independently; both share clk and rst_n.
//
// state | meaning
// IDLE  | waiting for den_in; a strobe here is accepted and latched
// BUSY  | transaction in flight; drdy_out asserts while lat_cnt == 1
module drp_adc_responder #(
    parameter int CONV_CYCLES = 26,
    parameter int DRP_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [6:0]  daddr_in,
    input  logic [15:0] di_in,
    output logic [15:0] do_out,
    output logic        drdy_out,
    output logic        eoc_out,
    output logic [4:0]  channel_out,
    input  logic [47:0] sample_in,
    output logic        busy_err
);

    localparam logic [6:0] ADDR_AUX6  = 7'h16;
    localparam logic [6:0] ADDR_AUX7  = 7'h17;
    localparam logic [6:0] ADDR_AUX14 = 7'h1E;
    localparam logic [6:0] ADDR_AUX15 = 7'h1F;
    localparam logic [6:0] ADDR_CFG   = 7'h41;

    localparam logic [9:0] TIMER_TC = 10'(CONV_CYCLES - 1);
    localparam logic [3:0] LAT_LOAD = 4'(DRP_LATENCY);

    typedef enum logic {IDLE, BUSY} drp_state_t;

    drp_state_t  state, state_nxt;
    logic [3:0]  lat_cnt, lat_cnt_nxt;
    logic        drdy;
    logic [15:0] rdata;
    logic [15:0] rd_mux;
    logic        seq_en;
    logic        seq_en_eff;
    logic        accept;
    logic        cfg_wr;

    logic [9:0]  timer;
    logic [1:0]  ptr;
    logic [11:0] lane;
    logic [4:0]  chan_code;
    logic [15:0] result_q [4];

    logic        unused_di;
    assign unused_di = ^di_in[15:1];

    assign accept = den_in && (state == IDLE);
    assign cfg_wr = accept && dwe_in && (daddr_in == ADDR_CFG);

    // A CFG write steers the sequencer from its own accept edge onward.
    assign seq_en_eff = cfg_wr ? di_in[0] : seq_en;

    always_comb begin
        rd_mux = 16'h0000;
        case (daddr_in)
            ADDR_AUX6:  rd_mux = result_q[0];
            ADDR_AUX7:  rd_mux = result_q[1];
            ADDR_AUX14: rd_mux = result_q[2];
            ADDR_AUX15: rd_mux = result_q[3];
            ADDR_CFG:   rd_mux = {15'h0000, seq_en};
            default:    rd_mux = 16'h0000;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        drdy        = 1'b0;
        case (state)
            IDLE: begin
                if (den_in) begin
                    state_nxt   = BUSY;
                    lat_cnt_nxt = LAT_LOAD;
                end
            end
            BUSY: begin
                if (lat_cnt == 4'd1) begin
                    drdy      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    lat_cnt_nxt = lat_cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign drdy_out = drdy;
    assign do_out   = drdy ? rdata : 16'h0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lat_cnt  <= 4'd0;
            rdata    <= 16'h0000;
            seq_en   <= 1'b1;
            busy_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
            if (accept) begin
                rdata <= dwe_in ? 16'h0000 : rd_mux;
            end
            if (cfg_wr) begin
                seq_en <= di_in[0];
            end
            if (den_in && (state == BUSY)) begin
                busy_err <= 1'b1;
            end
        end
    end

    always_comb begin
        lane      = sample_in[11:0];
        chan_code = 5'd6;
        case (ptr)
            2'd0: begin lane = sample_in[11:0];  chan_code = 5'd6;  end
            2'd1: begin lane = sample_in[23:12]; chan_code = 5'd7;  end
            2'd2: begin lane = sample_in[35:24]; chan_code = 5'd14; end
            2'd3: begin lane = sample_in[47:36]; chan_code = 5'd15; end
            default: begin lane = sample_in[11:0]; chan_code = 5'd6; end
        endcase
    end

    // The lane is captured at the edge closing the eoc_out cycle, so a read
    // accepted on that same edge still returns the previous result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer       <= 10'd0;
            eoc_out     <= 1'b0;
            channel_out <= 5'd0;
            ptr         <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                result_q[i] <= 16'h0000;
            end
        end else begin
            eoc_out <= 1'b0;
            if (!seq_en_eff) begin
                timer <= 10'd0;
            end else if (timer == TIMER_TC) begin
                timer       <= 10'd0;
                eoc_out     <= 1'b1;
                channel_out <= chan_code;
            end else begin
                timer <= timer + 10'd1;
            end
            if (eoc_out) begin
                result_q[ptr] <= {lane, 4'b0000};
                ptr           <= ptr + 2'd1;
            end
        end
    end

endmodule

// File: doc/drp_adc_responder.md
DRP_ADC_RESPONDER -- requirements
Module: drp_adc_responder

Interface
REQ-001 The block SHALL have parameter CONV_CYCLES, default 26, giving the clocks per conversion (legal range 4..1023).
REQ-002 The block SHALL have parameter DRP_LATENCY, default 4, giving the clocks from an accepted den_in to drdy_out (legal range 1..15).
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 den_in  input  1  DRP enable, one-cycle request strobe.
REQ-006 dwe_in  input  1  DRP write enable, qualified by den_in.
REQ-007 daddr_in  input  7  DRP register address.
REQ-008 di_in  input  16  DRP write data.
REQ-009 do_out  output  16  DRP read data.
REQ-010 drdy_out  output  1  DRP transaction-complete pulse.
REQ-011 eoc_out  output  1  end-of-conversion pulse.
REQ-012 channel_out  output  5  auxiliary channel of the most recent conversion.
REQ-013 sample_in  input  48  four 12-bit analog samples: [11:0] aux6, [23:12] aux7, [35:24] aux14, [47:36] aux15.
REQ-014 busy_err  output  1  sticky flag: a request arrived while a transaction was in flight.

Function
REQ-015 Register map SHALL be: 0x16 aux6, 0x17 aux7, 0x1E aux14, 0x1F aux15 (read-only result registers), and 0x41 CFG (read/write, 16 bits, only bit0 implemented as SEQ_EN).
REQ-016 Reads of CFG bits [15:1] SHALL return 0, and writes to them SHALL be discarded.
REQ-017 Reads of any unmapped address SHALL return 0x0000, and writes to any address other than 0x41 SHALL be discarded.
REQ-018 The sequencer SHALL convert while SEQ_EN=1, in the fixed order aux6, aux7, aux14, aux15, then wrap to aux6.
REQ-019 A conversion timer SHALL count 0..CONV_CYCLES-1; on the terminal count the sequencer SHALL:
- store {sample_in lane, 4'b0000} into the current channel's result register;
- pulse eoc_out high for exactly one clock;
- load channel_out with the converted channel (6, 7, 14 or 15);
- advance to the next channel.
REQ-020 Sample lane capture SHALL occur in the same clock as the eoc_out pulse.
REQ-021 When SEQ_EN=0, the timer SHALL hold at 0 and the channel pointer SHALL hold, with no eoc_out pulses and result registers retained.
REQ-022 On a 0->1 transition of SEQ_EN, conversion SHALL restart from the held channel, and the first eoc_out SHALL follow CONV_CYCLES clocks after the write's accept cycle.
REQ-023 The DRP state machine SHALL have states IDLE and BUSY.
REQ-024 In IDLE, den_in=1 SHALL accept the request, latch the address, read data and write data, and move the machine to BUSY with a latency counter loaded to DRP_LATENCY.
REQ-025 Read data SHALL be sampled in the accept cycle; a same-cycle conversion update SHALL NOT be visible to that read.
REQ-026 A write to CFG SHALL take effect in the accept cycle.
REQ-027 In BUSY, the counter SHALL decrement each clock; at count 1 the machine SHALL assert drdy_out for exactly one clock and return to IDLE.
REQ-028 A new den_in SHALL be accepted no earlier than the clock after drdy_out, so back-to-back requests achieve one transaction per DRP_LATENCY+1 clocks.
REQ-029 do_out SHALL equal the latched read data during the drdy_out cycle and 0x0000 at all other times; for write transactions it SHALL be 0x0000.
REQ-030 A den_in received in BUSY, or in the drdy_out cycle, SHALL be ignored and SHALL set busy_err; busy_err SHALL clear only on reset.
REQ-031 DRP transactions and conversions SHALL proceed independently, so eoc_out and drdy_out may assert in the same clock.

Reset
REQ-032 While rst_n=0, the following SHALL be forced immediately (asynchronously):
- do_out=0x0000, drdy_out=0, eoc_out=0, channel_out=0, busy_err=0;
- CFG=0x0001, result registers=0x0000;
- timer=0, channel pointer=aux6, DRP state=IDLE.
REQ-033 Reset asserted mid-transaction SHALL abort it with no drdy_out; after release, the first conversion SHALL complete CONV_CYCLES clocks after the first rising edge with rst_n=1.

Verification
REQ-034 Reset release, sample_in lanes 0x123/0x456/0x789/0xABC -> eoc_out pulses at clocks 26, 52, 78, 104 with channel_out 6, 7, 14, 15; reads of 0x16/0x17/0x1E/0x1F return 0x1230/0x4560/0x7890/0xABC0.
REQ-035 Read of 0x41 after reset -> drdy_out 4 clocks after den_in, do_out=0x0001 in that cycle only; read of 0x00 -> 0x0000.
REQ-036 Write 0x0000 to 0x41, hold 200 clocks -> no eoc_out; then write 0xFFFF -> CFG reads 0x0001, first eoc_out 26 clocks after the write accept.
REQ-037 Second den_in 2 clocks after the first -> ignored, single drdy_out, busy_err=1 until reset.
REQ-038 den_in to 0x16 in the same clock as an aux6 eoc_out -> returns the old value; the next read returns the new value.
REQ-039 Assert rst_n low 2 clocks after den_in -> no drdy_out, all outputs 0, CFG=0x0001 after release.
